// File: rtl/hazard_grid_accumulator_if.sv
// rtl/hazard_grid_accumulator_if.sv - hazard box input and occupancy grid output bundle
interface hazard_grid_accumulator_if #(
  parameter int COORD_W     = 11,
  parameter int GRID_ROWS   = 4,
  parameter int GRID_COLS   = 8,
  parameter int MAX_HAZARDS = 16
);
  localparam int CNT_W = $clog2(MAX_HAZARDS + 1);

  logic                         hz_valid;
  logic                         hz_ready;
  logic [COORD_W-1:0]           hz_top;
  logic [COORD_W-1:0]           hz_left;
  logic [COORD_W-1:0]           hz_bottom;
  logic [COORD_W-1:0]           hz_right;
  logic                         hz_last;
  logic                         grid_valid;
  logic                         grid_ready;
  logic [GRID_ROWS*GRID_COLS-1:0] grid;
  logic [CNT_W-1:0]             hz_count;
  logic                         overflow;
  logic                         bad_box;

  modport slave (
    input  hz_valid, hz_top, hz_left, hz_bottom, hz_right, hz_last, grid_ready,
    output hz_ready, grid_valid, grid, hz_count, overflow, bad_box
  );

  modport master (
    output hz_valid, hz_top, hz_left, hz_bottom, hz_right, hz_last, grid_ready,
    input  hz_ready, grid_valid, grid, hz_count, overflow, bad_box
  );
endinterface

// File: rtl/hazard_grid_accumulator.sv
// rtl/hazard_grid_accumulator.sv - paints hazard boxes into a row-major occupancy grid, one row per cycle
module hazard_grid_accumulator #(
  parameter int COORD_W     = 11,
  parameter int GRID_ROWS   = 4,
  parameter int GRID_COLS   = 8,
  parameter int CELL_SHIFT  = 3,
  parameter int MAX_HAZARDS = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_grid_accumulator_if.slave bus
);
  localparam int RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int CW = $clog2(MAX_HAZARDS + 1);
  localparam int N  = GRID_ROWS * GRID_COLS;

  typedef enum logic [1:0] {ACCEPT, PAINT, OUTPUT} state_t;

  state_t                 state;
  state_t                 next_state;
  logic                   active;
  logic                   ready;
  logic                   gvalid;
  logic [N-1:0]           grid_q;
  logic [CW-1:0]          count_q;
  logic                   over_q;
  logic                   bad_q;
  logic                   last_q;
  logic [RW-1:0]          cur_row;
  logic [RW-1:0]          end_row;
  logic [GRID_COLS-1:0]   col_mask;

  logic [COORD_W-1:0]     top_cell;
  logic [COORD_W-1:0]     left_cell;
  logic [COORD_W-1:0]     bottom_cell;
  logic [COORD_W-1:0]     right_cell;
  logic [COORD_W-1:0]     end_row_full;
  logic [COORD_W-1:0]     end_col_full;
  logic [GRID_COLS-1:0]   new_mask;
  logic                   is_bad;
  logic                   is_over;
  logic                   is_off;
  logic                   do_paint;
  logic                   accept;

  assign top_cell    = bus.hz_top    >> CELL_SHIFT;
  assign left_cell   = bus.hz_left   >> CELL_SHIFT;
  assign bottom_cell = bus.hz_bottom >> CELL_SHIFT;
  assign right_cell  = bus.hz_right  >> CELL_SHIFT;

  // Only the far edges are clamped; a near edge past the grid makes the box off-grid.
  assign end_row_full = (bottom_cell > COORD_W'(GRID_ROWS - 1)) ? COORD_W'(GRID_ROWS - 1) : bottom_cell;
  assign end_col_full = (right_cell  > COORD_W'(GRID_COLS - 1)) ? COORD_W'(GRID_COLS - 1) : right_cell;

  assign is_bad   = (bus.hz_top > bus.hz_bottom) || (bus.hz_left > bus.hz_right);
  assign is_over  = (count_q == CW'(MAX_HAZARDS));
  assign is_off   = (top_cell >= COORD_W'(GRID_ROWS)) || (left_cell >= COORD_W'(GRID_COLS));
  assign do_paint = !is_bad && !is_over && !is_off;
  assign accept   = bus.hz_valid && ready;

  always_comb begin
    new_mask = '0;
    for (int c = 0; c < GRID_COLS; c++) begin
      new_mask[c] = (COORD_W'(c) >= left_cell) && (COORD_W'(c) <= end_col_full);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCEPT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    gvalid     = 1'b0;
    case (state)
      ACCEPT: begin
        ready = active;
        if (bus.hz_valid && active) begin
          if (do_paint) begin
            next_state = PAINT;
          end else if (bus.hz_last) begin
            next_state = OUTPUT;
          end
        end
      end
      PAINT: begin
        if (cur_row == end_row) begin
          next_state = last_q ? OUTPUT : ACCEPT;
        end
      end
      OUTPUT: begin
        gvalid = 1'b1;
        if (bus.grid_ready) begin
          next_state = ACCEPT;
        end
      end
      default: next_state = ACCEPT;
    endcase
  end

  // Holds hz_ready low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
    end else begin
      active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_q   <= '0;
      count_q  <= '0;
      over_q   <= 1'b0;
      bad_q    <= 1'b0;
      last_q   <= 1'b0;
      cur_row  <= '0;
      end_row  <= '0;
      col_mask <= '0;
    end else begin
      case (state)
        ACCEPT: begin
          if (accept) begin
            last_q <= bus.hz_last;
            if (is_bad) begin
              bad_q <= 1'b1;
            end else if (is_over) begin
              over_q <= 1'b1;
            end else if (!is_off) begin
              count_q  <= count_q + CW'(1);
              cur_row  <= RW'(top_cell);
              end_row  <= RW'(end_row_full);
              col_mask <= new_mask;
            end
          end
        end
        PAINT: begin
          for (int r = 0; r < GRID_ROWS; r++) begin
            if (cur_row == RW'(r)) begin
              grid_q[r*GRID_COLS +: GRID_COLS] <= grid_q[r*GRID_COLS +: GRID_COLS] | col_mask;
            end
          end
          if (cur_row != end_row) begin
            cur_row <= cur_row + RW'(1);
          end
        end
        OUTPUT: begin
          if (bus.grid_ready) begin
            grid_q  <= '0;
            count_q <= '0;
            over_q  <= 1'b0;
            bad_q   <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hz_ready   = ready;
  assign bus.grid_valid = gvalid;
  assign bus.grid       = grid_q;
  assign bus.hz_count   = count_q;
  assign bus.overflow   = over_q;
  assign bus.bad_box    = bad_q;
endmodule

// File: tb/tb_hazard_grid_accumulator.sv
// tb/tb_hazard_grid_accumulator.sv - self-checking bench for hazard_grid_accumulator
module tb_hazard_grid_accumulator;
  localparam int COORD_W     = 11;
  localparam int GRID_ROWS   = 4;
  localparam int GRID_COLS   = 8;
  localparam int CELL_SHIFT  = 3;
  localparam int MAX_HAZARDS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_grid_accumulator_if #(
    .COORD_W(COORD_W), .GRID_ROWS(GRID_ROWS), .GRID_COLS(GRID_COLS), .MAX_HAZARDS(MAX_HAZARDS)
  ) bus ();

  hazard_grid_accumulator #(
    .COORD_W(COORD_W), .GRID_ROWS(GRID_ROWS), .GRID_COLS(GRID_COLS),
    .CELL_SHIFT(CELL_SHIFT), .MAX_HAZARDS(MAX_HAZARDS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_grid;
  int          m_count;
  bit          m_over;
  bit          m_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    m_grid  = '0;
    m_count = 0;
    m_over  = 0;
    m_bad   = 0;
  endfunction

  // Applies one box to the frame model; returns the paint cycles it should cost.
  function automatic int model_box(input int t, input int l, input int b, input int r);
    int r0, r1, c0, c1;
    if (t > b || l > r) begin
      m_bad = 1;
      return 0;
    end
    if (m_count == MAX_HAZARDS) begin
      m_over = 1;
      return 0;
    end
    r0 = t >> CELL_SHIFT;
    c0 = l >> CELL_SHIFT;
    if (r0 >= GRID_ROWS || c0 >= GRID_COLS) return 0;
    r1 = b >> CELL_SHIFT;
    c1 = r >> CELL_SHIFT;
    m_count++;
    for (int y = 0; y < GRID_ROWS; y++)
      for (int x = 0; x < GRID_COLS; x++)
        if (y >= r0 && y <= r1 && x >= c0 && x <= c1) m_grid[y*GRID_COLS + x] = 1'b1;
    return ((r1 < GRID_ROWS) ? r1 : GRID_ROWS - 1) - r0 + 1;
  endfunction

  task automatic send_box(input string tag, input int t, input int l, input int b, input int r,
                          input bit last);
    int k;
    int busy;
    int exp;
    exp = model_box(t, l, b, r);
    @(negedge clk);
    bus.hz_valid  = 1'b1;
    bus.hz_top    = COORD_W'(t);
    bus.hz_left   = COORD_W'(l);
    bus.hz_bottom = COORD_W'(b);
    bus.hz_right  = COORD_W'(r);
    bus.hz_last   = last;
    k = 0;
    while (bus.hz_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready"}, 64'(bus.hz_ready), 64'(1));
    @(negedge clk);
    bus.hz_valid = 1'b0;
    bus.hz_last  = 1'b0;
    busy = 0;
    while (bus.hz_ready !== 1'b1 && bus.grid_valid !== 1'b1 && busy < 50) begin
      @(negedge clk);
      busy++;
    end
    check({tag, " busy"}, 64'(busy), 64'(exp));
  endtask

  task automatic expect_frame(input string tag, input int hold);
    int k;
    k = 0;
    while (bus.grid_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, " grid_valid"}, 64'(bus.grid_valid), 64'(1));
    check({tag, " grid"},       64'(bus.grid),       64'(m_grid));
    check({tag, " hz_count"},   64'(bus.hz_count),   64'(m_count));
    check({tag, " overflow"},   64'(bus.overflow),   64'(m_over));
    check({tag, " bad_box"},    64'(bus.bad_box),    64'(m_bad));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold grid"},  64'(bus.grid),       64'(m_grid));
      check({tag, " hold count"}, 64'(bus.hz_count),   64'(m_count));
      check({tag, " hold valid"}, 64'(bus.grid_valid), 64'(1));
      check({tag, " hold ready"}, 64'(bus.hz_ready),   64'(0));
    end
    bus.grid_ready = 1'b1;
    @(negedge clk);
    bus.grid_ready = 1'b0;
    check({tag, " clr valid"}, 64'(bus.grid_valid), 64'(0));
    check({tag, " clr ready"}, 64'(bus.hz_ready),   64'(1));
    check({tag, " clr grid"},  64'(bus.grid),       64'(0));
    check({tag, " clr count"}, 64'(bus.hz_count),   64'(0));
    check({tag, " clr flags"}, 64'({bus.overflow, bus.bad_box}), 64'(0));
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, l, b, r, nb;
    bus.hz_valid   = 1'b0;
    bus.hz_top     = '0;
    bus.hz_left    = '0;
    bus.hz_bottom  = '0;
    bus.hz_right   = '0;
    bus.hz_last    = 1'b0;
    bus.grid_ready = 1'b0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst hz_ready",   64'(bus.hz_ready),   64'(0));
    check("rst grid_valid", 64'(bus.grid_valid), 64'(0));
    check("rst grid",       64'(bus.grid),       64'(0));
    check("rst count",      64'(bus.hz_count),   64'(0));
    check("rst flags",      64'({bus.overflow, bus.bad_box}), 64'(0));
    rst_n = 1'b1;
    check("rel hz_ready low", 64'(bus.hz_ready), 64'(0));
    @(negedge clk);
    check("rel hz_ready high", 64'(bus.hz_ready), 64'(1));

    // Single one-cell box
    send_box("single", 1, 1, 5, 2, 1'b1);
    check("single literal", 64'(bus.grid), 64'(32'h0000_0001));
    expect_frame("single", 0);

    // Two boxes, second spans two rows
    send_box("two a", 1, 1, 5, 2, 1'b0);
    send_box("two b", 20, 5, 24, 8, 1'b1);
    check("two literal", 64'(bus.grid), 64'(32'h0303_0001));
    expect_frame("two", 1);

    // Box clamped to the whole grid
    send_box("full", 0, 0, 2047, 2047, 1'b1);
    check("full literal", 64'(bus.grid), 64'(32'hFFFF_FFFF));
    expect_frame("full", 0);

    // Quota: 17 one-cell boxes then a last box
    for (int i = 0; i < 17; i++) begin
      t = $urandom_range(0, GRID_ROWS - 1) * 8 + $urandom_range(0, 7);
      l = $urandom_range(0, GRID_COLS - 1) * 8 + $urandom_range(0, 7);
      send_box("quota", t, l, t, l, 1'b0);
    end
    send_box("quota last", 0, 0, 0, 0, 1'b1);
    check("quota count literal", 64'(bus.hz_count), 64'(16));
    check("quota overflow literal", 64'(bus.overflow), 64'(1));
    expect_frame("quota", 5);

    // Invalid box, then off-grid box
    send_box("bad", 5, 1, 2, 2, 1'b1);
    check("bad literal", 64'(bus.bad_box), 64'(1));
    expect_frame("bad", 0);
    send_box("offgrid", 40, 0, 45, 3, 1'b1);
    expect_frame("offgrid", 0);

    // Reset while painting a 4-row box
    @(negedge clk);
    bus.hz_valid  = 1'b1;
    bus.hz_top    = COORD_W'(0);
    bus.hz_left   = COORD_W'(0);
    bus.hz_bottom = COORD_W'(31);
    bus.hz_right  = COORD_W'(7);
    bus.hz_last   = 1'b1;
    @(negedge clk);
    bus.hz_valid = 1'b0;
    bus.hz_last  = 1'b0;
    @(negedge clk);
    check("abort painting", 64'(bus.hz_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("abort ready",  64'(bus.hz_ready),   64'(0));
    check("abort valid",  64'(bus.grid_valid), 64'(0));
    check("abort grid",   64'(bus.grid),       64'(0));
    check("abort count",  64'(bus.hz_count),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort ready after release", 64'(bus.hz_ready), 64'(1));
    model_clear();
    send_box("after abort", 2, 9, 3, 12, 1'b1);
    expect_frame("after abort", 0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        t = $urandom_range(0, 47);
        b = ($urandom_range(0, 7) == 0) ? 2047 : $urandom_range(0, 47);
        l = $urandom_range(0, 79);
        r = ($urandom_range(0, 7) == 0) ? 2047 : $urandom_range(0, 79);
        send_box("rnd", t, l, b, r, i == nb - 1);
      end
      expect_frame("rnd", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
